rr_arbiter_param: RTL
=====================

Name: rr_arbiter_param

Overview:
Parametrised round-robin bus arbiter. It is the next generation of the 3-master/2-slave arbiter and sits between N_MST bus masters and N_SLV slaves. It grants one master at a time, holds the grant until the transaction completes (falling edge of ack), then rotates priority. New relative to the 3-master version: a generic master/slave count, registered gnt/sel, a slave_id latched at grant time, a hold-timeout watchdog, request-abandon release and decode-error flagging.

Parameters:
N_MST, 3, number of requesting masters (2..16)
N_SLV, 2, number of slaves; sel is one-hot of this width (1..16)
SID_W, 1, width of each master's slave_id field (>= clog2(N_SLV), min 1)
MAX_HOLD, 16, maximum cycles one grant may last; 0 disables the watchdog
CNT_W, 8, hold counter width (2^CNT_W > MAX_HOLD)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
req  in  N_MST  request per master, level
slave_id  in  N_MST*SID_W  packed target slave index, master i at [i*SID_W +: SID_W]
ack  in  1  transaction-in-progress flag from the selected slave; completion = 1->0 transition
gnt  out  N_MST  one-hot grant, registered
sel  out  N_SLV  one-hot slave select, registered
owner  out  clog2(N_MST) (min 1)  index of the current owner, valid while busy
busy  out  1  a grant is active
timeout  out  1  one-cycle pulse when the watchdog revokes a grant
decerr  out  1  one-cycle pulse when a grant is issued with slave_id >= N_SLV

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, gnt=0, sel=0, owner=0, busy=0, timeout=0, decerr=0, ack_r=0, hold_cnt=0, last pointer = N_MST-1 (first arbitration favours master 0).
- ack_r is ack registered. cmd_done = ack_r & ~ack.
- RR pick: search masters last+1, last+2, ... wrapping, ending at last itself. The first with req=1 wins. No requester means no pick.
- States: IDLE, GRANT.
- IDLE: at the edge where req != 0, go to GRANT. At that same edge load gnt=onehot(pick), owner=pick and busy=1. Latch the winner's slave_id into sid_q and load sel=onehot(sid_q). Latency is one edge from a sampled req to visible gnt.
- GRANT: sid_q is frozen and later slave_id changes are ignored. hold_cnt increments each cycle and saturates.
- GRANT release causes, in priority order: (1) cmd_done; (2) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1; (3) abandon: req[owner]=0 with ack=0 and ack_r=0.
- On release: last=owner and hold_cnt=0.
- On release, if another pick exists (excluding no one), regrant at the same edge with no idle bubble. gnt switches directly from the old one-hot to the new one-hot. Otherwise go to IDLE with gnt=0, sel=0 and busy=0.
- Cause (2) pulses timeout for exactly one cycle. If cause (1) and cause (2) occur at the same edge, cause (1) wins and timeout stays 0.
- A release by a master that is still requesting puts that master last in the rotation. It is regranted immediately only if it is the sole requester.
- decerr: at any grant edge where the latched sid_q >= N_SLV, sel=0 and decerr pulses for one cycle. The grant itself is still issued so the watchdog or abandon can clear it.
- ack is ignored in IDLE, but ack_r still tracks ack. A falling edge of ack in IDLE causes no action.
- gnt is always zero or one-hot. sel is always zero or one-hot. busy == |gnt.
- rst asserted mid-transaction aborts at the next edge: all outputs go to their reset values and no timeout or decerr pulse is produced.

Decomposition:
- Package rr_arb_pkg holds: the state encoding (IDLE=1'b0, GRANT=1'b1), a clog2 helper function and a onehot-encode function.
- One sub-module, rr_pick. It is combinational: inputs req and last, outputs pick and valid; a rotate + priority-encode + unrotate structure.
- The FSM, counters and output registers stay in rr_arbiter_param.

Test Plan:
(Defaults N_MST=3, N_SLV=2, MAX_HOLD=16.)
1. Reset/basic: hold rst=0 for 2 cycles, then req=3'b001 and slave_id=3'b010 (master0 targets slave 0). Required: gnt=001, sel=01, owner=0 one edge later. Drive ack 1 for 3 cycles then 0: gnt=000 and busy=0 on the edge after ack falls, with req dropped.
2. Rotation: req=3'b111 held, each transaction ack 1->0. Grant order 001 -> 010 -> 100 -> 001, back-to-back with no idle cycle between grants.
3. Slave latch: master1 granted with slave_id[1]=1 (sel=10). Toggle slave_id[1] to 0 mid-grant: sel stays 10 until release.
4. Watchdog: master2 granted, ack held at 1 for 20 cycles. Required: timeout pulses for one cycle exactly 16 cycles after the grant edge, and gnt moves to the next requester or to 000. Also drive cmd_done on the 16th cycle: timeout=0.
5. Abandon/decerr: master0 granted, drops req with ack never asserted: gnt=000 on the next edge. With N_SLV=3, SID_W=2 and slave_id=2'b11: grant issued, sel=000, decerr pulses once.
6. Reset mid-op: rst=0 while gnt=010 and ack=1. Required: all outputs 0 at the next edge, and the first post-reset grant goes to master0 when req=111.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the parametrised round-robin arbiter.
// Holds the FSM encoding, a minimum-1 clog2 and a one-hot bit encoder.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Bit `pos` of the one-hot encoding of `idx`.
  function automatic logic onehot_bit(input int idx, input int pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/rr_arbiter_param_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ... wrapping,
// ending at last, via rotate, lowest-set-bit encode, then unrotate.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          valid
);

  logic [N-1:0] w_rot;
  int           w_enc;

  always_comb begin
    w_rot = N'({req, req} >> (int'(last) + 1));
    valid = |req;
    w_enc = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = i;
    end
    pick = IW'((int'(last) + 1 + w_enc) % N);
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter for N_MST masters onto N_SLV slaves with registered
// grant/select, latched slave id, hold watchdog, abandon release and decode error.
module rr_arbiter_param
  import rr_arb_pkg::*;
#(
  parameter int N_MST    = 3,
  parameter int N_SLV    = 2,
  parameter int SID_W    = 1,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_MST-1:0]                  req,
  input  logic [N_MST*SID_W-1:0]            slave_id,
  input  logic                              ack,
  output logic [N_MST-1:0]                  gnt,
  output logic [N_SLV-1:0]                  sel,
  output logic [clog2_min1(N_MST)-1:0]      owner,
  output logic                              busy,
  output logic                              timeout,
  output logic                              decerr,
  output state_t                            dbg_state
);

  localparam int OW = clog2_min1(N_MST);

  // Handshake: a master holds req high; it owns the bus while its gnt bit is
  // set; the slave raises ack during the transfer and its fall ends the grant.
  state_t             r_state, w_state_n;
  logic [N_MST-1:0]   r_gnt, w_gnt_n;
  logic [N_SLV-1:0]   r_sel, w_sel_n;
  logic [OW-1:0]      r_owner, w_owner_n, r_last, w_last_n;
  logic [OW-1:0]      w_pick_last, w_pick;
  logic               r_busy, w_busy_n, r_timeout, w_timeout_n, r_decerr, w_decerr_n;
  logic               r_ack, w_valid, w_done, w_wd, w_abandon, w_release, w_do_grant;
  logic [CNT_W-1:0]   r_hold, w_hold_n;
  logic [SID_W-1:0]   r_sid, w_sid_n, w_pick_sid;

  // While granted, the next search starts after the current owner.
  assign w_pick_last = (r_state == GRANT) ? r_owner : r_last;

  rr_pick #(.N(N_MST), .IW(OW)) u_pick (
    .req   (req),
    .last  (w_pick_last),
    .pick  (w_pick),
    .valid (w_valid)
  );

  assign w_pick_sid = slave_id[int'(w_pick)*SID_W +: SID_W];
  assign w_done     = r_ack & ~ack;
  assign w_wd       = (MAX_HOLD != 0) && (r_hold == CNT_W'(MAX_HOLD - 1));
  assign w_abandon  = ~req[r_owner] & ~ack & ~r_ack;
  assign w_release  = (r_state == GRANT) & (w_done | w_wd | w_abandon);

  always_comb begin
    w_state_n   = r_state;
    w_gnt_n     = r_gnt;
    w_sel_n     = r_sel;
    w_owner_n   = r_owner;
    w_busy_n    = r_busy;
    w_timeout_n = 1'b0;
    w_decerr_n  = 1'b0;
    w_hold_n    = r_hold;
    w_last_n    = r_last;
    w_sid_n     = r_sid;
    w_do_grant  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) w_do_grant = 1'b1;
      end
      GRANT: begin
        if (w_release) begin
          w_last_n    = r_owner;
          w_hold_n    = '0;
          w_timeout_n = w_wd & ~w_done;
          if (w_valid) begin
            w_do_grant = 1'b1;
          end else begin
            w_state_n = IDLE;
            w_gnt_n   = '0;
            w_sel_n   = '0;
            w_owner_n = '0;
            w_busy_n  = 1'b0;
          end
        end else if (r_hold != {CNT_W{1'b1}}) begin
          w_hold_n = r_hold + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
    // Fresh grant from idle or back-to-back regrant on release.
    if (w_do_grant) begin
      w_state_n  = GRANT;
      w_owner_n  = w_pick;
      w_busy_n   = 1'b1;
      w_hold_n   = '0;
      w_sid_n    = w_pick_sid;
      w_decerr_n = int'(w_pick_sid) >= N_SLV;
      for (int i = 0; i < N_MST; i++) w_gnt_n[i] = onehot_bit(int'(w_pick), i);
      for (int j = 0; j < N_SLV; j++) w_sel_n[j] = onehot_bit(int'(w_pick_sid), j);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_decerr  <= 1'b0;
      r_ack     <= 1'b0;
      r_hold    <= '0;
      r_last    <= OW'(N_MST - 1);
      r_sid     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_gnt     <= w_gnt_n;
      r_sel     <= w_sel_n;
      r_owner   <= w_owner_n;
      r_busy    <= w_busy_n;
      r_timeout <= w_timeout_n;
      r_decerr  <= w_decerr_n;
      r_ack     <= ack;
      r_hold    <= w_hold_n;
      r_last    <= w_last_n;
      r_sid     <= w_sid_n;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign decerr    = r_decerr;
  assign dbg_state = r_state;

endmodule
